pipelined_shifter: RTL and testbench

- Parametrised, elastic-pipelined barrel shifter; successor to the datapath's single-cycle combinational shifter.
- Performs LSL/LSR/ASR/ROR on a WIDTH-bit operand with full ARM carry-out semantics and 8-bit register-specified shift amounts.
- Uses a valid/ready handshake so it can be placed between the register-read and ALU stages of the pipelined datapath.
- Passes a sideband tag through unchanged.

---
 rtl/pipelined_shifter_if.sv | 30 +++
 rtl/pipelined_shifter.sv | 110 +++++++++++
 tb/tb_pipelined_shifter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter: operation request, result and flush.
// master drives operations and consumes results; slave is the shifter itself.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sh;
    logic [WIDTH-1:0] in_data;
    logic [7:0]       in_amt;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_sh, in_data, in_amt, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_tag
    );

    modport slave (
        input  flush, in_valid, in_sh, in_data, in_amt, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Elastic STAGES-deep barrel shifter (LSL/LSR/ASR/ROR) with ARM carry-out and tag sideband.
// Define PIPELINED_SHIFTER_RRX_EN to make ROR by 0 perform RRX.
module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic               clk,
    input logic               reset,
    pipelined_shifter_if.slave bus
);
    localparam int         LW = $clog2(WIDTH);
    localparam logic [7:0] W8 = 8'(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam int RW = $bits(res_t);

    logic [WIDTH:0]   lsl_x, lsr_x, asr_x;
    logic [WIDTH-1:0] ror_d;
    logic [7:0]       asr_n;
    logic [LW-1:0]    ror_m;
    res_t             res0;

    // A spare bit next to the operand catches the last bit shifted out,
    // which is exactly the ARM carry for every amount including n=W and n>W.
    always_comb begin
        lsl_x = {1'b0, bus.in_data} << bus.in_amt;
        lsr_x = {bus.in_data, 1'b0} >> bus.in_amt;
        asr_n = (bus.in_amt >= W8) ? W8 : bus.in_amt;
        asr_x = $signed({bus.in_data, 1'b0}) >>> asr_n;
        ror_m = bus.in_amt[LW-1:0];
        ror_d = (bus.in_data >> ror_m) | (bus.in_data << (WIDTH - int'(ror_m)));

        res0.tag   = bus.in_tag;
        res0.data  = bus.in_data;
        res0.carry = bus.in_carry;
        if (bus.in_amt != 8'd0) begin
            case (bus.in_sh)
                2'b00: begin
                    res0.data  = lsl_x[WIDTH-1:0];
                    res0.carry = lsl_x[WIDTH];
                end
                2'b01: begin
                    res0.data  = lsr_x[WIDTH:1];
                    res0.carry = lsr_x[0];
                end
                2'b10: begin
                    res0.data  = asr_x[WIDTH:1];
                    res0.carry = asr_x[0];
                end
                default: begin
                    // Rotated MSB equals data[m-1], or data[W-1] when m wraps to 0.
                    res0.data  = ror_d;
                    res0.carry = ror_d[WIDTH-1];
                end
            endcase
        end
`ifdef PIPELINED_SHIFTER_RRX_EN
        else if (bus.in_sh == 2'b11) begin
            res0.data  = {bus.in_carry, bus.in_data[WIDTH-1:1]};
            res0.carry = bus.in_data[0];
        end
`endif
    end

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] vld_src;
    logic [STAGES:1] rdy;
    res_t [STAGES:1] pipe;
    res_t [STAGES:1] res_src;

    // Stage k is fed by stage k-1; stage 1 is fed by the freshly computed result.
    assign vld_src = STAGES'({vld_pipe, bus.in_valid});
    assign res_src = (RW*STAGES)'({pipe, res0});

    // A stage can take new data if it, or any stage after it, has a hole,
    // or the consumer is draining the last stage this cycle.
    for (genvar k = 1; k <= STAGES; k++) begin : g_rdy
        assign rdy[k] = bus.out_ready || !(&vld_pipe[STAGES:k]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            pipe     <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (rdy[k] && vld_src[k]) pipe[k] <= res_src[k];
            end
            if (bus.flush) begin
                vld_pipe <= '0;
            end else begin
                for (int k = 1; k <= STAGES; k++) begin
                    if (rdy[k]) vld_pipe[k] <= vld_src[k];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[1];
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_data  = pipe[STAGES].data;
    assign bus.out_carry = pipe[STAGES].carry;
    assign bus.out_tag   = pipe[STAGES].tag;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32, STAGES=2): directed vectors,
// latency, back-pressure, asynchronous reset and flush.
module tb_pipelined_shifter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipelined_shifter_if #(.WIDTH(W), .TAG_W(4)) bus();
    pipelined_shifter #(.WIDTH(W), .STAGES(2), .TAG_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic [3:0]   t;
    } exp_t;

    typedef struct {
        logic [1:0]   sh;
        logic [W-1:0] d;
        logic [7:0]   amt;
        logic         c;
        logic [W-1:0] ed;
        logic         ec;
    } vec_t;

`ifdef PIPELINED_SHIFTER_RRX_EN
    localparam logic [W-1:0] RRX_D = 32'h8000_0001;
`else
    localparam logic [W-1:0] RRX_D = 32'h0000_0003;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] sh, input logic [W-1:0] d, input logic [7:0] amt,
                         input logic c, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_sh    = sh;
        bus.in_data  = d;
        bus.in_amt   = amt;
        bus.in_carry = c;
        bus.in_tag   = tag;
    endtask

    // Offer one operation, record its expected result, hold until it is accepted.
    task automatic send(input logic [1:0] sh, input logic [W-1:0] d, input logic [7:0] amt,
                        input logic c, input logic [3:0] tag,
                        input logic [W-1:0] ed, input logic ec);
        int w = 0;
        exp_t e;
        drive(sh, d, amt, c, tag);
        e.d = ed; e.c = ec; e.t = tag;
        exp_q.push_back(e);
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) chk("send_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_tag), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_data",  64'(bus.out_data),  64'(e.d));
                chk("out_carry", 64'(bus.out_carry), 64'(e.c));
                chk("out_tag",   64'(bus.out_tag),   64'(e.t));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vt[16];

    initial begin
        vt = '{
            '{2'b00, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1},
            '{2'b01, 32'h8000_0001, 8'd40,  1'b1, 32'h0000_0000, 1'b0},
            '{2'b11, 32'h0000_000F, 8'd36,  1'b0, 32'hF000_0000, 1'b1},
            '{2'b11, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1},
            '{2'b00, 32'h1234_5678, 8'd4,   1'b0, 32'h2345_6780, 1'b1},
            '{2'b01, 32'h1234_5678, 8'd4,   1'b0, 32'h0123_4567, 1'b1},
            '{2'b01, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1},
            '{2'b10, 32'h7FFF_FFFF, 8'd40,  1'b1, 32'h0000_0000, 1'b0},
            '{2'b10, 32'h8000_0000, 8'd255, 1'b0, 32'hFFFF_FFFF, 1'b1},
            '{2'b00, 32'hDEAD_BEEF, 8'd0,   1'b1, 32'hDEAD_BEEF, 1'b1},
            '{2'b11, 32'h0000_0003, 8'd0,   1'b1, RRX_D,         1'b1},
            '{2'b00, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0},
            '{2'b10, 32'h8000_0000, 8'd1,   1'b1, 32'hC000_0000, 1'b0},
            '{2'b11, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1},
            '{2'b01, 32'hFFFF_FFFF, 8'd31,  1'b0, 32'h0000_0001, 1'b1},
            '{2'b10, 32'h8000_0000, 8'd31,  1'b1, 32'hFFFF_FFFF, 1'b0}
        };

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_sh = 2'b00; bus.in_data = '0;
        bus.in_amt = 8'd0; bus.in_carry = 1'b0; bus.in_tag = 4'd0; bus.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
        chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Latency: ASR 0x80000000 by 4 emerges exactly two cycles after acceptance.
        begin
            exp_t e;
            drive(2'b10, 32'h8000_0000, 8'd4, 1'b0, 4'd1);
            e.d = 32'hF800_0000; e.c = 1'b0; e.t = 4'd1;
            exp_q.push_back(e);
            chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            chk("lat_1cyc", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
            chk("lat_2cyc", 64'(bus.out_valid), 64'd1);
        end
        drain();

        foreach (vt[i])
            send(vt[i].sh, vt[i].d, vt[i].amt, vt[i].c, 4'(i), vt[i].ed, vt[i].ec);
        drain();

        // Back-pressure: consumer stalls while tags 1..6 are offered back to back.
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(2'b01, 32'hA000_0000 | 32'(i), 8'd0, 1'(i), 4'(i),
                         32'hA000_0000 | 32'(i), 1'(i));
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("bp_hold_tag",   64'(bus.out_tag),   64'd1);
                    chk("bp_hold_data",  64'(bus.out_data),  64'hA000_0001);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    chk("bp_no_gap", 64'(bus.out_valid), 64'd1);
                end
            end
        join
        drain();

        // Asynchronous reset between edges with two operations in flight.
        bus.out_ready = 1'b0;
        send(2'b00, 32'hFFFF_0000, 8'd0, 1'b1, 4'd7, 32'hFFFF_0000, 1'b1);
        send(2'b00, 32'h0F0F_0F0F, 8'd0, 1'b1, 4'd8, 32'h0F0F_0F0F, 1'b1);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_data",  64'(bus.out_data),  64'd0);
        chk("arst_out_carry", 64'(bus.out_carry), 64'd0);
        chk("arst_out_tag",   64'(bus.out_tag),   64'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("arst_quiet", 64'(bus.out_valid), 64'd0);
        end

        // Flush with a live input transfer in the same cycle.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(2'b00, 32'h1111_1111, 8'd0, 1'b0, 4'd9, 32'h1111_1111, 1'b0);
        drive(2'b00, 32'h2222_2222, 8'd0, 1'b0, 4'd10);
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (4) begin
            @(negedge clk);
            chk("fl_quiet", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(2'b11, 32'h0000_00F0, 8'd4, 1'b0, 4'd11, 32'h0000_000F, 1'b0);
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
